// File: rtl/matmul_out_serializer_pkg.sv
// Shared matmul parameters: default geometry, derived slice sizing helpers and
// the output serializer controller state encoding.
package matmul_out_serializer_pkg;

    localparam int unsigned DEF_WIDTH_OUT     = 16;
    localparam int unsigned DEF_CHUNK_SIZE    = 4;
    localparam int unsigned DEF_NUM_CORES_A   = 4;
    localparam int unsigned DEF_NUM_CORES_B   = 1;
    localparam int unsigned DEF_TOTAL_MODULES = 2;

    localparam int unsigned SLICE_W    = DEF_WIDTH_OUT * DEF_CHUNK_SIZE;
    localparam int unsigned NUM_SLICES = DEF_NUM_CORES_A * DEF_NUM_CORES_B * DEF_TOTAL_MODULES;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_STREAM = 1'b1;

    function automatic int unsigned calc_slice_w(input int unsigned width_out,
                                                 input int unsigned chunk_size);
        return width_out * chunk_size;
    endfunction

    function automatic int unsigned calc_num_slices(input int unsigned cores_a,
                                                    input int unsigned cores_b,
                                                    input int unsigned modules);
        return cores_a * cores_b * modules;
    endfunction

    // Index width never collapses to zero bits, even for a single-slice tile.
    function automatic int unsigned calc_idx_w(input int unsigned num_slices);
        return (num_slices > 1) ? $clog2(num_slices) : 1;
    endfunction

endpackage

// File: rtl/out_pingpong_buf.sv
// Two-entry tile buffer: storage, per-entry full flags, write pointer (lowest
// empty entry) and read pointer (oldest full entry).
module out_pingpong_buf #(
    parameter int unsigned DATA_W = 512
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_pop_i,
    output logic [1:0]        full_o,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [1:0]        full_q, full_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr;
    logic              wr_ok;
    logic [DATA_W-1:0] mem_q [2];

    assign wr_ptr = full_q[0];
    assign wr_ok  = wr_en_i && !clr_i && (full_q != 2'b11);

    // When nothing is held, the freshly written entry becomes the oldest one,
    // which keeps draining in capture order regardless of which index it is.
    always_comb begin
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        if (rd_pop_i) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
        if (wr_ok) begin
            full_d[wr_ptr] = 1'b1;
            if (full_q == 2'b00) begin
                rd_ptr_d = wr_ptr;
            end
        end
        if (clr_i) begin
            full_d   = '0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full_q   <= '0;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr] <= wr_data_i;
        end
    end

    assign full_o    = full_q;
    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/matmul_out_serializer.sv
// Serializes completed matmul tiles into MSB-first slices over a valid/ready
// stream, double-buffering tiles so a new result can land while one drains.
module matmul_out_serializer
    import matmul_out_serializer_pkg::*;
#(
    parameter int unsigned WIDTH_OUT     = DEF_WIDTH_OUT,
    parameter int unsigned CHUNK_SIZE    = DEF_CHUNK_SIZE,
    parameter int unsigned NUM_CORES_A   = DEF_NUM_CORES_A,
    parameter int unsigned NUM_CORES_B   = DEF_NUM_CORES_B,
    parameter int unsigned TOTAL_MODULES = DEF_TOTAL_MODULES,
    localparam int unsigned SLICE_WIDTH  = calc_slice_w(WIDTH_OUT, CHUNK_SIZE),
    localparam int unsigned SLICE_COUNT  = calc_num_slices(NUM_CORES_A, NUM_CORES_B, TOTAL_MODULES),
    localparam int unsigned TILE_W       = SLICE_WIDTH * SLICE_COUNT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [TILE_W-1:0]      in_data,
    output logic [SLICE_WIDTH-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            tile_count
);

    localparam int unsigned      IDX_W    = calc_idx_w(SLICE_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICE_COUNT - 1);

    logic [1:0]             full;
    logic [TILE_W-1:0]      rd_data;
    logic                   state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            tile_count_q, tile_count_d;
    logic                   capture;
    logic                   drop;
    logic                   handshake;
    logic                   last_hs;
    logic [SLICE_WIDTH-1:0] slice;

    // Occupancy is judged at the start of the cycle, so a tile arriving while
    // both entries are full is dropped even if the last slice leaves now.
    assign capture   = in_valid && !clr && (full != 2'b11);
    assign drop      = in_valid && !clr && (full == 2'b11);
    assign handshake = (state_q == ST_STREAM) && m_ready;
    assign last_hs   = handshake && (idx_q == LAST_IDX);

    out_pingpong_buf #(
        .DATA_W(TILE_W)
    ) u_buf (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .clr_i     (clr),
        .wr_en_i   (capture),
        .wr_data_i (in_data),
        .rd_pop_i  (last_hs && !clr),
        .full_o    (full),
        .rd_data_o (rd_data)
    );

    always_comb begin
        slice = '0;
        for (int unsigned k = 0; k < SLICE_COUNT; k++) begin
            if (idx_q == IDX_W'(k)) begin
                slice = rd_data[(SLICE_COUNT - k) * SLICE_WIDTH - 1 -: SLICE_WIDTH];
            end
        end
    end

    // IDLE looks at the same-cycle capture so slice 0 appears one cycle after
    // capture; STREAM stays put across tiles when another tile is ready.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        overflow_d   = overflow_q | drop;
        tile_count_d = tile_count_q;
        case (state_q)
            ST_IDLE: begin
                if (capture || (full != 2'b00)) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (handshake) begin
                    if (last_hs) begin
                        idx_d        = '0;
                        tile_count_d = tile_count_q + 16'd1;
                        state_d      = ((full == 2'b11) || capture) ? ST_STREAM : ST_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clr) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            overflow_d   = 1'b0;
            tile_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            tile_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            overflow_q   <= overflow_d;
            tile_count_q <= tile_count_d;
        end
    end

    assign m_valid    = (state_q == ST_STREAM);
    assign m_data     = m_valid ? slice : '0;
    assign m_last     = m_valid && (idx_q == LAST_IDX);
    assign busy       = (full != 2'b00);
    assign overflow   = overflow_q;
    assign tile_count = tile_count_q;

endmodule

// File: doc/matmul_out_serializer.md
MATMUL_OUT_SERIALIZER -- requirements
Module: matmul_out_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH_OUT, default 16, meaning element width in bits.
REQ-002 The block SHALL have parameter CHUNK_SIZE, default 4, meaning elements per output slice.
REQ-003 The block SHALL have parameters NUM_CORES_A (default 4), NUM_CORES_B (default 1) and TOTAL_MODULES (default 2), which together set the slices per tile.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous soft clear.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a one-cycle pulse from the upstream accumulator-done signal.
REQ-009 The block SHALL have port in_data, input, NUM_SLICES*SLICE_W bits: the full tile result, with the MSB slice first.
REQ-010 The block SHALL have port m_data, output, SLICE_W bits: the current slice.
REQ-011 The block SHALL have port m_valid, output, 1 bit: the slice is valid.
REQ-012 The block SHALL have port m_ready, input, 1 bit: the consumer accepts the slice.
REQ-013 The block SHALL have port m_last, output, 1 bit: the final slice of the tile.
REQ-014 The block SHALL have port busy, output, 1 bit: at least one buffer is occupied.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a tile is dropped.
REQ-016 The block SHALL have port tile_count, output, 16 bits: number of tiles fully emitted, wrapping modulo 2^16.

Function
REQ-017 The block SHALL use SLICE_W = WIDTH_OUT*CHUNK_SIZE and NUM_SLICES = NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES.
REQ-018 The block SHALL hold two tile buffers (ping-pong); each buffer is either EMPTY or FULL.
REQ-019 When in_valid is high and at least one buffer is EMPTY at the start of the cycle, the block SHALL capture in_data into the EMPTY buffer with the lower index.
REQ-020 When in_valid is high and both buffers are FULL at the start of the cycle, the block SHALL drop the data and set overflow, even if the last-slice handshake completes in the same cycle.
REQ-021 The controller SHALL have two states: IDLE (m_valid=0) and STREAM (m_valid=1).
REQ-022 On IDLE with a FULL buffer, the controller SHALL move to STREAM; a capture at cycle t SHALL give m_valid=1 with slice 0 at cycle t+1.
REQ-023 The block SHALL emit slice k = in_data[(NUM_SLICES-k)*SLICE_W-1 -: SLICE_W] for k = 0..NUM_SLICES-1, MSB slice first.
REQ-024 A handshake SHALL occur when m_valid and m_ready are both high; only a handshake SHALL advance the slice index.
REQ-025 While m_valid=1 and m_ready=0, the block SHALL hold m_data and m_last stable.
REQ-026 The block SHALL drive m_last=1 only on slice NUM_SLICES-1.
REQ-027 On the last-slice handshake, the block SHALL mark the draining buffer EMPTY, increment tile_count, and reset the slice index to 0.
REQ-028 After that last-slice handshake, if the other buffer is FULL, the block SHALL present its slice 0 on the next cycle with no bubble; otherwise it SHALL return to IDLE.
REQ-029 The block SHALL drain buffers strictly in capture order (FIFO).
REQ-030 The block SHALL drive busy=1 whenever either buffer is FULL.
REQ-031 When clr is high, the block SHALL empty both buffers, go to IDLE, and zero the slice index, overflow and tile_count; clr SHALL take priority over in_valid in the same cycle.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force m_valid=0, m_last=0, m_data=0, busy=0, overflow=0, tile_count=0, both buffers EMPTY, and state IDLE.
REQ-033 Reset asserted mid-tile SHALL discard all buffered data; after deassertion the block SHALL be in IDLE.

Structure
REQ-034 SLICE_W, NUM_SLICES and the state encoding (IDLE=0, STREAM=1) SHALL live in the shared matmul parameter package.
REQ-035 The two-entry buffer SHALL be a single sub-module, out_pingpong_buf, containing the storage, full flags and read/write pointers; the top level SHALL hold the FSM, slice mux and counters.

Verification (defaults: SLICE_W=64, NUM_SLICES=8)
REQ-036 Single tile, m_ready=1: one in_valid pulse at t -> m_valid for cycles t+1..t+8, slices in MSB-first order, m_last only at t+8, tile_count=1.
REQ-037 Back-to-back tiles: pulses at t and t+3 -> 16 consecutive valid slices with no gap; m_last at t+8 and t+16.
REQ-038 Backpressure: m_ready low for 5 cycles at slice 3 -> m_data is held for those 5 cycles; no slice is lost or duplicated.
REQ-039 Overflow: three pulses while m_ready=0 -> the third is dropped, overflow=1, and only tiles 1 and 2 are emitted.
REQ-040 Boundary: both buffers FULL and in_valid on the same cycle as the last-slice handshake -> overflow=1 and the new tile is dropped.
REQ-041 Reset at slice 4, then a new pulse -> outputs go to 0 at once; the new tile is emitted from slice 0 and tile_count=1.
